// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: execute stage of a 5-stage in-order pipeline, ending in the EX/MEM register.
//
// Operands are forwarded from the MEM and WB stages. MEM wins over WB, and register 0 is never
// forwarded. The ALU covers add/sub/and/or/nor/slt/sll/srl. Shifts act on the B operand (rt),
// as in MIPS.
//
// Optional feature (macro EXEC_STAGE_MULDIV_EN): a signed multiply (aluop=10, funct=0x18) with
// MUL_LAT cycles of EX occupancy. stall_out holds upstream while the multiply runs. With the
// macro undefined, stall_out is tied to 0 and funct 0x18 decodes as unknown, giving 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid, flush           instruction present in EX / squash it
//   regdst..regwrite          decoded control bits
//   aluop, funct, shamt       ALU operation select
//   reg1, reg2, sign_ex       register operands and sign-extended immediate
//   rs, rt, rd                register addresses
//   regwrite_mem, rd_mem, alu_result_mem   MEM-stage forwarding source
//   regwrite_wb, rd_wb, wb_result          WB-stage forwarding source
//   stall_out                 hold IF/ID and EX inputs stable
//   mem_*                     EX/MEM pipeline register outputs
module exec_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic              memtoreg,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              regwrite,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [DATA_W-1:0] sign_ex,
  input  logic [RA_W-1:0]   rs,
  input  logic [RA_W-1:0]   rt,
  input  logic [RA_W-1:0]   rd,
  input  logic              regwrite_mem,
  input  logic [RA_W-1:0]   rd_mem,
  input  logic [DATA_W-1:0] alu_result_mem,
  input  logic              regwrite_wb,
  input  logic [RA_W-1:0]   rd_wb,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall_out,
  output logic              mem_valid,
  output logic              mem_memtoreg,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_regwrite,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [RA_W-1:0]   mem_rd
);

  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res, ex_result;
  logic              load;

  // Operand forwarding: MEM beats WB; r0 is hard-wired zero and never forwarded.
  always_comb begin
    fwd_a = reg1;
    if (regwrite_mem && rd_mem == rs && rd_mem != '0)     fwd_a = alu_result_mem;
    else if (regwrite_wb && rd_wb == rs && rd_wb != '0)   fwd_a = wb_result;
    fwd_b = reg2;
    if (regwrite_mem && rd_mem == rt && rd_mem != '0)     fwd_b = alu_result_mem;
    else if (regwrite_wb && rd_wb == rt && rd_wb != '0)   fwd_b = wb_result;
  end

  assign alu_b = alusrc ? sign_ex : fwd_b;

  always_comb begin
    alu_res = '0;
    case (aluop)
      2'b00: alu_res = fwd_a + alu_b;
      2'b01: alu_res = fwd_a - alu_b;
      2'b10: begin
        case (funct)
          6'h20:   alu_res = fwd_a + alu_b;
          6'h22:   alu_res = fwd_a - alu_b;
          6'h24:   alu_res = fwd_a & alu_b;
          6'h25:   alu_res = fwd_a | alu_b;
          6'h27:   alu_res = ~(fwd_a | alu_b);
          6'h2A:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
          6'h00:   alu_res = alu_b << shamt;
          6'h02:   alu_res = alu_b >> shamt;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_STAGE_MULDIV_EN
  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} mul_state_e;

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mul_a_q, mul_b_q;
  logic [DATA_W-1:0] product;
  logic              is_mul, mul_start, mul_done, stall_int;

  assign is_mul    = in_valid && aluop == 2'b10 && funct == 6'h18;
  assign mul_start = state_q == StIdle && is_mul && !flush;
  // Low DATA_W bits of a product are identical for signed and unsigned operands.
  assign product   = mul_a_q * mul_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (mul_start) begin
        mul_a_q <= fwd_a;
        mul_b_q <= alu_b;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (mul_start) begin
          state_d = StBusy;
          cnt_d   = CNT_W'(MUL_LAT - 2);
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_int = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      StIdle: stall_int = mul_start;
      StBusy: begin
        stall_int = cnt_q != '0;
        mul_done  = cnt_q == '0 && !flush;
      end
      default: stall_int = 1'b0;
    endcase
  end

  assign stall_out = stall_int && !rst;
  assign ex_result = mul_done ? product : alu_res;
`else
  assign stall_out = 1'b0;
  assign ex_result = alu_res;
`endif

  // Upstream holds the instruction stable while stalled, so in_valid is still high in the
  // final multiply cycle.
  assign load = in_valid && !flush && !stall_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_memtoreg   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_regwrite   <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
    end else begin
      mem_valid    <= load;
      mem_memtoreg <= load && memtoreg;
      mem_memread  <= load && memread;
      mem_memwrite <= load && memwrite;
      mem_regwrite <= load && regwrite;
      if (load) begin
        mem_alu_result <= ex_result;
        mem_store_data <= fwd_b;
        mem_rd         <= regdst ? rd : rt;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_pipe.sv
module tb_exec_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush;
  logic        regdst, alusrc, memtoreg, memread, memwrite, regwrite;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] reg1, reg2, sign_ex;
  logic [4:0]  rs, rt, rd;
  logic        regwrite_mem, regwrite_wb;
  logic [4:0]  rd_mem, rd_wb;
  logic [31:0] alu_result_mem, wb_result;
  logic        stall_out;
  logic        mem_valid, mem_memtoreg, mem_memread, mem_memwrite, mem_regwrite;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_rd;

  int n_asserts = 0;
  int n_fail    = 0;

  exec_stage_pipe #(.DATA_W(32), .RA_W(5), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .regdst(regdst), .alusrc(alusrc), .memtoreg(memtoreg), .memread(memread),
    .memwrite(memwrite), .regwrite(regwrite), .aluop(aluop), .funct(funct), .shamt(shamt),
    .reg1(reg1), .reg2(reg2), .sign_ex(sign_ex), .rs(rs), .rt(rt), .rd(rd),
    .regwrite_mem(regwrite_mem), .rd_mem(rd_mem), .alu_result_mem(alu_result_mem),
    .regwrite_wb(regwrite_wb), .rd_wb(rd_wb), .wb_result(wb_result),
    .stall_out(stall_out), .mem_valid(mem_valid), .mem_memtoreg(mem_memtoreg),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; flush = 0;
    regdst = 0; alusrc = 0; memtoreg = 0; memread = 0; memwrite = 0; regwrite = 0;
    aluop = 0; funct = 0; shamt = 0; reg1 = 0; reg2 = 0; sign_ex = 0;
    rs = 0; rt = 0; rd = 0;
    regwrite_mem = 0; rd_mem = 0; alu_result_mem = 0;
    regwrite_wb = 0; rd_wb = 0; wb_result = 0;
  endtask

  // R-type style instruction, no hazards, destination rd=9.
  task automatic drive_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    in_valid = 1; regdst = 1; regwrite = 1;
    aluop = op; funct = fn; shamt = sh; reg1 = a; reg2 = b;
    rs = 1; rt = 2; rd = 9;
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] regv);
    if (addr != 0 && regwrite_mem && rd_mem == addr) return alu_result_mem;
    if (addr != 0 && regwrite_wb && rd_wb == addr) return wb_result;
    return regv;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [4:0] sh, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return 32'd0;
    case (fn)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h00: return b << sh;
      6'h02: return b >> sh;
      default: return 32'd0;
    endcase
  endfunction

  logic [5:0]  fn_pool [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h18,
                                6'h3F};
  logic        exp_valid;
  logic [31:0] exp_res, exp_store, op_a, op_b;
  logic [4:0]  exp_rd;
  logic [3:0]  exp_ctrl;

  initial begin
    clear_inputs();
    rst = 1;
    #2;
    chk("reset_valid", mem_valid, 0);
    chk("reset_ctrl", {mem_memtoreg, mem_memread, mem_memwrite, mem_regwrite}, 0);
    chk("reset_result", mem_alu_result, 0);
    chk("reset_store", mem_store_data, 0);
    chk("reset_rd", mem_rd, 0);
    chk("reset_stall", stall_out, 0);
    tick();
    rst = 0;

    // Basic add, one-edge latency.
    drive_op(2'b00, 6'h00, 0, 32'd5, 32'd7);
    #1 chk("add_stall", stall_out, 0);
    tick();
    chk("add_valid", mem_valid, 1);
    chk("add_result", mem_alu_result, 32'd12);
    chk("add_rd", mem_rd, 5'd9);
    chk("add_ctrl", {mem_memtoreg, mem_memread, mem_memwrite, mem_regwrite}, 4'b0001);

    // MEM has priority over WB.
    drive_op(2'b00, 6'h00, 0, 32'd55, 32'd1);
    rs = 3; rt = 4;
    regwrite_mem = 1; rd_mem = 3; alu_result_mem = 100;
    regwrite_wb = 1; rd_wb = 3; wb_result = 200;
    tick();
    chk("fwd_mem_prio", mem_alu_result, 32'd101);

    // WB only.
    regwrite_mem = 0;
    tick();
    chk("fwd_wb", mem_alu_result, 32'd201);

    // r0 never forwarded.
    drive_op(2'b00, 6'h00, 0, 32'd10, 32'd1);
    rs = 0; rt = 4; regwrite_mem = 1; rd_mem = 0; alu_result_mem = 100;
    tick();
    chk("fwd_r0", mem_alu_result, 32'd11);

    drive_op(2'b10, 6'h2A, 0, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("slt_neg", mem_alu_result, 32'd1);

    drive_op(2'b01, 6'h00, 0, 32'd0, 32'd1);
    tick();
    chk("sub_wrap", mem_alu_result, 32'hFFFF_FFFF);

    drive_op(2'b10, 6'h00, 5'd31, 32'd1, 32'd1);
    tick();
    chk("sll_31", mem_alu_result, 32'h8000_0000);

    // Immediate source; store data stays forwarded B.
    drive_op(2'b00, 6'h00, 0, 32'd3, 32'd40);
    alusrc = 1; sign_ex = 32'd4; regdst = 0; memwrite = 1; regwrite = 0;
    tick();
    chk("imm_result", mem_alu_result, 32'd7);
    chk("imm_store", mem_store_data, 32'd40);
    chk("imm_rd", mem_rd, 5'd2);
    chk("imm_ctrl", {mem_memtoreg, mem_memread, mem_memwrite, mem_regwrite}, 4'b0010);

    // Bubbles.
    drive_op(2'b00, 6'h00, 0, 32'd1, 32'd1);
    memread = 1; memtoreg = 1;
    in_valid = 0;
    tick();
    chk("bubble_valid", mem_valid, 0);
    chk("bubble_ctrl", {mem_memtoreg, mem_memread, mem_memwrite, mem_regwrite}, 0);
    in_valid = 1; flush = 1;
    tick();
    chk("flush_valid", mem_valid, 0);
    chk("flush_ctrl", {mem_memtoreg, mem_memread, mem_memwrite, mem_regwrite}, 0);

`ifdef EXEC_STAGE_MULDIV_EN
    // 6 * -7 with MUL_LAT=4: stall for 3 cycles, result at the 4th edge.
    drive_op(2'b10, 6'h18, 0, 32'd6, 32'hFFFF_FFF9);
    rd = 7;
    #1 chk("mul_stall_c0", stall_out, 1);
    tick();
    chk("mul_valid_e1", mem_valid, 0);
    chk("mul_stall_c1", stall_out, 1);
    tick();
    chk("mul_stall_c2", stall_out, 1);
    tick();
    chk("mul_stall_c3", stall_out, 0);
    chk("mul_valid_e3", mem_valid, 0);
    tick();
    chk("mul_valid", mem_valid, 1);
    chk("mul_result", mem_alu_result, 32'hFFFF_FFD6);
    chk("mul_rd", mem_rd, 5'd7);
    clear_inputs();
    tick();

    // Flush in the second BUSY cycle.
    drive_op(2'b10, 6'h18, 0, 32'd6, 32'd7);
    tick();
    tick();
    flush = 1;
    tick();
    chk("mflush_valid", mem_valid, 0);
    drive_op(2'b00, 6'h00, 0, 32'd5, 32'd7);
    #1 chk("mflush_stall", stall_out, 0);
    tick();
    chk("mflush_next_valid", mem_valid, 1);
    chk("mflush_next_result", mem_alu_result, 32'd12);

    // Reset mid-multiply.
    drive_op(2'b10, 6'h18, 0, 32'd6, 32'd7);
    tick();
    tick();
    rst = 1;
    #1;
    chk("mrst_stall", stall_out, 0);
    chk("mrst_valid", mem_valid, 0);
    chk("mrst_result", mem_alu_result, 0);
    chk("mrst_store", mem_store_data, 0);
    chk("mrst_rd", mem_rd, 0);
    drive_op(2'b00, 6'h00, 0, 32'd5, 32'd7);
    tick();
    rst = 0;
    #1 chk("mrst_idle_stall", stall_out, 0);
    tick();
    chk("mrst_next_valid", mem_valid, 1);
    chk("mrst_next_result", mem_alu_result, 32'd12);
`else
    // Without the multiplier, funct 0x18 is an unknown op.
    drive_op(2'b10, 6'h18, 0, 32'd6, 32'hFFFF_FFF9);
    #1 chk("nomul_stall", stall_out, 0);
    tick();
    chk("nomul_valid", mem_valid, 1);
    chk("nomul_result", mem_alu_result, 0);
`endif

    // Randomized single-cycle traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      clear_inputs();
      in_valid = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      {regdst, alusrc, memtoreg, memread, memwrite, regwrite} = 6'($urandom);
      aluop = 2'($urandom);
      funct = fn_pool[$urandom_range(0, 9)];
`ifdef EXEC_STAGE_MULDIV_EN
      if (funct == 6'h18) funct = 6'h20;
`endif
      shamt = 5'($urandom);
      reg1 = $urandom; reg2 = $urandom; sign_ex = $urandom;
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      regwrite_mem = 1'($urandom); rd_mem = 5'($urandom_range(0, 3));
      alu_result_mem = $urandom;
      regwrite_wb = 1'($urandom); rd_wb = 5'($urandom_range(0, 3));
      wb_result = $urandom;

      exp_valid = in_valid && !flush;
      op_a      = ref_fwd(rs, reg1);
      exp_store = ref_fwd(rt, reg2);
      op_b      = alusrc ? sign_ex : exp_store;
      exp_res   = ref_alu(aluop, funct, shamt, op_a, op_b);
      exp_rd    = regdst ? rd : rt;
      exp_ctrl  = exp_valid ? {memtoreg, memread, memwrite, regwrite} : 4'b0;
      #1 chk("rnd_stall", stall_out, 0);
      tick();
      chk("rnd_valid", mem_valid, exp_valid);
      chk("rnd_ctrl", {mem_memtoreg, mem_memread, mem_memwrite, mem_regwrite}, exp_ctrl);
      if (exp_valid) begin
        chk("rnd_result", mem_alu_result, exp_res);
        chk("rnd_store", mem_store_data, exp_store);
        chk("rnd_rd", mem_rd, exp_rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
